// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX operand forwarding, load-use stall, taken-branch
// IF/ID flush and multi-cycle EX hold with a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned AW       = 5,
  parameter int unsigned MC_LAT   = 4,
  parameter int unsigned CNT_W    = 16,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_branch_taken,
  input  logic [AW-1:0]    ex_rs,
  input  logic [AW-1:0]    ex_rt,
  input  logic [AW-1:0]    ex_wreg,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic             ex_mc_start,
  input  logic [AW-1:0]    mem_wreg,
  input  logic             mem_regwrite,
  input  logic [AW-1:0]    wb_wreg,
  input  logic             wb_regwrite,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             ex_hold,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {IDLE, MC_BUSY} state_t;

  localparam logic [3:0] MC_RELOAD = 4'(MC_LAT - 2);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_mc_cnt, w_mc_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_mem_ok, w_wb_ok, w_ex_ok, w_lu, w_mc_active;

  // A register-0 destination is treated as "writes nothing" when ZERO_REG is set.
  assign w_mem_ok = mem_regwrite && !(ZERO_REG && (mem_wreg == '0));
  assign w_wb_ok  = wb_regwrite  && !(ZERO_REG && (wb_wreg  == '0));
  assign w_ex_ok  = ex_memread && ex_regwrite && !(ZERO_REG && (ex_wreg == '0));

  assign w_lu = w_ex_ok && ((id_uses_rs && (id_rs == ex_wreg)) ||
                            (id_uses_rt && (id_rt == ex_wreg)));

  assign w_mc_active = (r_state == MC_BUSY) || ((r_state == IDLE) && ex_mc_start);

  always_comb begin
    forward_a = 2'd0;
    forward_b = 2'd0;
    if (w_mem_ok && (mem_wreg == ex_rs))     forward_a = 2'd2;
    else if (w_wb_ok && (wb_wreg == ex_rs))  forward_a = 2'd1;
    if (w_mem_ok && (mem_wreg == ex_rt))     forward_b = 2'd2;
    else if (w_wb_ok && (wb_wreg == ex_rt))  forward_b = 2'd1;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_mc_cnt_nxt = r_mc_cnt;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_bubble  = 1'b0;
    ifid_flush   = 1'b0;
    ex_hold      = 1'b0;
    mc_busy      = 1'b0;

    case (r_state)
      IDLE: begin
        if (ex_mc_start) begin
          w_state_nxt  = MC_BUSY;
          w_mc_cnt_nxt = MC_RELOAD;
        end
      end
      MC_BUSY: begin
        if (r_mc_cnt == '0) w_state_nxt = IDLE;
        else                w_mc_cnt_nxt = r_mc_cnt - 4'd1;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Stalls win over a taken branch; ID stays frozen so the branch is flushed later.
    if (w_mc_active) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ex_hold    = 1'b1;
      mc_busy    = 1'b1;
    end else if (w_lu) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (id_branch_taken) begin
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_mc_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
      if (!pc_write && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default instance plus a CNT_W=3 instance
// sharing the same stimulus for counter saturation.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
  logic       id_uses_rs, id_uses_rt, id_branch_taken;
  logic       ex_regwrite, ex_memread, ex_mc_start, mem_regwrite, wb_regwrite;

  logic [1:0]  forward_a, forward_b, s_forward_a, s_forward_b;
  logic        pc_write, ifid_write, idex_bubble, ifid_flush, ex_hold, mc_busy;
  logic        s_pc_write, s_ifid_write, s_idex_bubble, s_ifid_flush, s_ex_hold, s_mc_busy;
  logic [15:0] stall_cnt;
  logic [2:0]  s_stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.AW(5), .MC_LAT(4), .CNT_W(16), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_branch_taken(id_branch_taken),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_mc_start(ex_mc_start),
    .mem_wreg(mem_wreg), .mem_regwrite(mem_regwrite),
    .wb_wreg(wb_wreg), .wb_regwrite(wb_regwrite),
    .forward_a(forward_a), .forward_b(forward_b), .pc_write(pc_write),
    .ifid_write(ifid_write), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .ex_hold(ex_hold), .mc_busy(mc_busy), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.AW(5), .MC_LAT(4), .CNT_W(3), .ZERO_REG(1'b1)) dut_sat (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_branch_taken(id_branch_taken),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_mc_start(ex_mc_start),
    .mem_wreg(mem_wreg), .mem_regwrite(mem_regwrite),
    .wb_wreg(wb_wreg), .wb_regwrite(wb_regwrite),
    .forward_a(s_forward_a), .forward_b(s_forward_b), .pc_write(s_pc_write),
    .ifid_write(s_ifid_write), .idex_bubble(s_idex_bubble), .ifid_flush(s_ifid_flush),
    .ex_hold(s_ex_hold), .mc_busy(s_mc_busy), .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the stall-control group: pc_write, ifid_write, idex_bubble, ifid_flush, ex_hold, mc_busy.
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {pc_write, ifid_write, idex_bubble, ifid_flush, ex_hold, mc_busy}, {26'd0, exp});
  endtask

  // Advance to just after the next rising edge, drive there, sample 1ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  localparam logic [5:0] RUN   = 6'b110000;
  localparam logic [5:0] LU    = 6'b001000;
  localparam logic [5:0] FLUSH = 6'b110100;
  localparam logic [5:0] HOLD  = 6'b000011;

  initial begin
    rst = 1'b0;
    {id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg} = '0;
    {id_uses_rs, id_uses_rt, id_branch_taken} = '0;
    {ex_regwrite, ex_memread, ex_mc_start, mem_regwrite, wb_regwrite} = '0;

    #2;
    chk("reset_ctl", {26'd0, pc_write, ifid_write, idex_bubble, ifid_flush, ex_hold, mc_busy}, {26'd0, RUN});
    chk("reset_fwd", {forward_a, forward_b}, 4'd0);
    chk("reset_cnt", stall_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // Forwarding
    next_cycle();
    mem_regwrite = 1; mem_wreg = 3; wb_regwrite = 1; wb_wreg = 3; ex_rs = 3; ex_rt = 3;
    settle();
    chk("fwd_a_mem", forward_a, 2);
    chk("fwd_b_mem", forward_b, 2);
    mem_regwrite = 0; ex_rt = 4;
    settle();
    chk("fwd_a_wb", forward_a, 1);
    chk("fwd_b_none", forward_b, 0);
    mem_regwrite = 1; mem_wreg = 0; wb_wreg = 0; ex_rs = 0;
    settle();
    chk("fwd_a_r0", forward_a, 0);
    chk("fwd_ctl_run", {26'd0, pc_write, ifid_write, idex_bubble, ifid_flush, ex_hold, mc_busy}, {26'd0, RUN});
    mem_regwrite = 0; wb_regwrite = 0;

    // Load-use: exactly one stall cycle
    next_cycle();
    ex_memread = 1; ex_regwrite = 1; ex_wreg = 5; id_rt = 5; id_uses_rt = 1;
    settle();
    chk_ctl("lu_stall", LU);
    chk("lu_cnt_before", stall_cnt, 0);
    next_cycle();
    ex_memread = 0; ex_regwrite = 0; id_uses_rt = 0;
    settle();
    chk_ctl("lu_release", RUN);
    chk("lu_cnt_after", stall_cnt, 1);
    next_cycle();
    ex_memread = 1; ex_regwrite = 1; ex_wreg = 5; id_rt = 5; id_uses_rt = 0;
    settle();
    chk_ctl("lu_no_use", RUN);
    ex_wreg = 0; id_rt = 0; id_uses_rt = 1;
    settle();
    chk_ctl("lu_r0", RUN);
    ex_memread = 0; ex_regwrite = 0; id_uses_rt = 0;

    // Multi-cycle: start re-asserted during MC_BUSY must be ignored
    next_cycle();
    chk("mc_cnt_before", stall_cnt, 1);
    ex_mc_start = 1;
    settle();
    chk_ctl("mc_c1", HOLD);
    next_cycle();
    settle();
    chk_ctl("mc_c2", HOLD);
    ex_mc_start = 0;
    next_cycle();
    settle();
    chk_ctl("mc_c3", HOLD);
    next_cycle();
    settle();
    chk_ctl("mc_c4", HOLD);
    next_cycle();
    settle();
    chk_ctl("mc_done", RUN);
    chk("mc_cnt_after", stall_cnt, 5);

    // Branch held during a multi-cycle op
    ex_mc_start = 1; id_branch_taken = 1;
    settle();
    chk_ctl("br_mc_c1", HOLD);
    next_cycle();
    ex_mc_start = 0;
    settle();
    chk_ctl("br_mc_c2", HOLD);
    next_cycle();
    settle();
    chk_ctl("br_mc_c3", HOLD);
    next_cycle();
    settle();
    chk_ctl("br_mc_c4", HOLD);
    next_cycle();
    settle();
    chk_ctl("br_flush", FLUSH);
    chk("cnt_9", stall_cnt, 9);
    chk("sat_cnt_7", s_stall_cnt, 7);
    next_cycle();
    id_branch_taken = 0;
    settle();
    chk_ctl("br_flush_end", RUN);

    // Branch coinciding with load-use
    id_branch_taken = 1; ex_memread = 1; ex_regwrite = 1; ex_wreg = 7; id_rs = 7; id_uses_rs = 1;
    settle();
    chk_ctl("br_lu_stall", LU);
    next_cycle();
    ex_memread = 0; ex_regwrite = 0; id_uses_rs = 0;
    settle();
    chk_ctl("br_lu_flush", FLUSH);
    chk("cnt_10", stall_cnt, 10);
    chk("sat_cnt_hold", s_stall_cnt, 7);
    id_branch_taken = 0;

    // Reset two cycles into MC_BUSY
    next_cycle();
    ex_mc_start = 1;
    settle();
    chk_ctl("rst_mc_c1", HOLD);
    next_cycle();
    ex_mc_start = 0;
    next_cycle();
    settle();
    chk_ctl("rst_mc_c3", HOLD);
    chk("cnt_12", stall_cnt, 12);
    rst = 1'b0;
    settle();
    chk_ctl("rst_abort", RUN);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_sat_cnt", s_stall_cnt, 0);
    rst = 1'b1;

    next_cycle();
    ex_mc_start = 1;
    settle();
    chk_ctl("post_rst_c1", HOLD);
    next_cycle();
    ex_mc_start = 0;
    settle();
    chk_ctl("post_rst_c2", HOLD);
    next_cycle();
    settle();
    chk_ctl("post_rst_c3", HOLD);
    next_cycle();
    settle();
    chk_ctl("post_rst_c4", HOLD);
    next_cycle();
    settle();
    chk_ctl("post_rst_done", RUN);
    chk("post_rst_cnt", stall_cnt, 4);
    chk("post_rst_sat_cnt", s_stall_cnt, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
